// File: rtl/uart_sipo_rx.sv
// uart_sipo_rx: oversampling UART frame receiver (serial in, parallel out).
//   Frame: start(0), 8 data bits LSB first, parity, stop(1).
//   Each bit is decided at its mid-bit sample point, counted from the start edge.
//   Build option: define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote
//   over rx_s at S-1, S and S+1. The decision then lands on S+1, and all later timing
//   moves one cycle later.
// Parameters:
//   OVERSAMPLE  baud_clk cycles per bit (even, >=4)
//   PARITY_ODD  0 = even parity expected, 1 = odd parity expected
// Ports:
//   baud_clk, reset_n (async, active low), data_rx (async serial line, idle high)
//   data_out/parity_rx   last received byte and its parity bit
//   data_valid           1-cycle pulse when data_out, parity_rx and the error flags update
//   parity_err/frame_err error qualifiers for data_out, held until the next data_valid
//   active_flag          high while a frame is being received
//   done_flag            high from data_valid until the next start edge
module uart_sipo_rx #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       baud_clk,
  input  logic       reset_n,
  input  logic       data_rx,
  output logic [7:0] data_out,
  output logic       parity_rx,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active_flag,
  output logic       done_flag
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int CW   = $clog2(11 * OVERSAMPLE + 2);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VD = 1;
`else
  localparam int VD = 0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nx;
  logic            rx_meta, rx_s;
  logic            armed;
  logic [CW-1:0]   cnt, next_s;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            bit_val;
  logic            decide;
  logic            start_edge;

  // Two-flop synchronizer. The flops reset to the idle (high) level, so reset does not
  // produce a false start edge.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= data_rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // rx_hist[0] holds rx_s from one cycle ago and rx_hist[1] from two cycles ago. On the
  // decision cycle S+1 they supply the S and S-1 samples.
  logic [1:0] rx_hist;
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) rx_hist <= 2'b11;
    else          rx_hist <= {rx_hist[0], rx_s};
  end
  assign bit_val = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign start_edge = (state == IDLE) && armed && !rx_s;
  // cnt is 0 on the first cycle after the start edge, so cycle k relative to the edge
  // shows cnt == k-1. That is why next_s starts at HALF-1.
  assign decide     = (state != IDLE) && (cnt == next_s);

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_edge) state_nx = START;
      START:   if (decide) state_nx = bit_val ? IDLE : DATA;
      DATA:    if (decide && bit_idx == 3'd7) state_nx = PARITY;
      PARITY:  if (decide) state_nx = STOP;
      STOP:    if (decide) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      next_s      <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      armed       <= 1'b0;
      data_out    <= 8'h00;
      parity_rx   <= 1'b0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (start_edge)          cnt <= '0;
      else if (state != IDLE)  cnt <= cnt + 1'b1;

      if (start_edge)  next_s <= CW'(HALF - 1 + VD);
      else if (decide) next_s <= next_s + CW'(OVERSAMPLE);

      if (state == IDLE && rx_s) armed <= 1'b1;

      if (start_edge) begin
        armed       <= 1'b0;
        bit_idx     <= '0;
        active_flag <= 1'b1;
        done_flag   <= 1'b0;
      end

      if (decide) begin
        case (state)
          START: if (bit_val) active_flag <= 1'b0;  // false start: drop quietly
          DATA: begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY: par_bit <= bit_val;
          STOP: begin
            data_valid  <= 1'b1;
            data_out    <= shreg;
            parity_rx   <= par_bit;
            parity_err  <= par_bit != (^shreg ^ PARITY_ODD);
            frame_err   <= !bit_val;
            done_flag   <= 1'b1;
            active_flag <= 1'b0;
            // A good stop bit allows a back-to-back start edge. After a break, wait for
            // the line to go high again.
            armed       <= bit_val;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// tb_uart_sipo_rx: directed bench for uart_sipo_rx (OVERSAMPLE=16, even parity).
module tb_uart_sipo_rx;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT = 172;   // pin to data_valid: 2 sync + HALF + 10*OS + 1 + vote
`else
  localparam int LAT = 171;
`endif

  logic       baud_clk = 1'b0;
  logic       reset_n;
  logic       data_rx;
  logic [7:0] data_out;
  logic       parity_rx, data_valid, parity_err, frame_err, active_flag, done_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic act_mid;
  int vq_cyc[$];
  logic [7:0] vq_data[$];

  uart_sipo_rx #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
    .baud_clk(baud_clk), .reset_n(reset_n), .data_rx(data_rx),
    .data_out(data_out), .parity_rx(parity_rx), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err),
    .active_flag(active_flag), .done_flag(done_flag)
  );

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;
  always @(negedge baud_clk) if (data_valid) begin
    vq_cyc.push_back(cyc);
    vq_data.push_back(data_out);
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge baud_clk); #1;
      data_rx = v;
    end
  endtask

  // Drive the first nbits of a frame on the pin, one bit per OS cycles. The pin is
  // inverted on frame cycle 'glitch'. c0 is the cycle on which the start bit is driven.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input int glitch, output int c0);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    c0 = 0;
    for (int b = 0; b < nbits; b++)
      for (int k = 0; k < OS; k++) begin
        @(posedge baud_clk); #1;
        if (b == 0 && k == 0) c0 = cyc;
        data_rx = (b * OS + k == glitch) ? ~fr[b] : fr[b];
        if (b * OS + k == 100) act_mid = active_flag;
      end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    data_rx = 1'b1;
    repeat (3) @(posedge baud_clk);
    @(negedge baud_clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", data_out); end
    checks++; if ({parity_rx, data_valid, parity_err, frame_err, active_flag, done_flag} !== 6'b0) begin
      errors++; $display("FAIL rst_flags: got %b exp 000000",
        {parity_rx, data_valid, parity_err, frame_err, active_flag, done_flag}); end
    @(posedge baud_clk); #1;
    reset_n = 1'b1;
    drive(1'b1, 20);
  endtask

  task automatic test_basic;
    int n0, c0;
    n0 = vq_cyc.size();
    send_frame(8'hA5, 1'b0, 1'b1, 11, -1, c0);
    drive(1'b1, 16);
    checks++; if (vq_cyc.size() !== n0 + 1) begin errors++; $display("FAIL basic_count: got %0d exp %0d", vq_cyc.size() - n0, 1); end
    checks++; if (vq_cyc[n0] - c0 !== LAT) begin errors++; $display("FAIL basic_latency: got %0d exp %0d", vq_cyc[n0] - c0, LAT); end
    checks++; if (vq_data[n0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h exp a5", vq_data[n0]); end
    checks++; if ({parity_rx, parity_err, frame_err} !== 3'b000) begin errors++; $display("FAIL basic_errs: got %b exp 000", {parity_rx, parity_err, frame_err}); end
    checks++; if (done_flag !== 1'b1) begin errors++; $display("FAIL basic_done: got %b exp 1", done_flag); end
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL basic_active_end: got %b exp 0", active_flag); end
    checks++; if (act_mid !== 1'b1) begin errors++; $display("FAIL basic_active_mid: got %b exp 1", act_mid); end
  endtask

  task automatic test_parity;
    int c0;
    send_frame(8'hA5, 1'b1, 1'b1, 11, -1, c0);
    drive(1'b1, 16);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL par_data: got %h exp a5", data_out); end
    checks++; if ({parity_rx, parity_err, frame_err} !== 3'b110) begin errors++; $display("FAIL par_errs: got %b exp 110", {parity_rx, parity_err, frame_err}); end
  endtask

  task automatic test_break;
    int n0, c0;
    n0 = vq_cyc.size();
    send_frame(8'h3C, 1'b0, 1'b0, 11, -1, c0);
    drive(1'b0, 40 * OS);
    checks++; if (vq_cyc.size() !== n0 + 1) begin errors++; $display("FAIL brk_count: got %0d exp 1", vq_cyc.size() - n0); end
    checks++; if ({data_out, frame_err} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL brk_ferr: got %h/%b exp 3c/1", data_out, frame_err); end
    checks++; if (active_flag !== 1'b0) begin errors++; $display("FAIL brk_no_rearm: got active %b exp 0", active_flag); end
    drive(1'b1, 32);
    send_frame(8'h01, 1'b1, 1'b1, 11, -1, c0);
    drive(1'b1, 16);
    checks++; if (vq_cyc.size() !== n0 + 2) begin errors++; $display("FAIL brk_next_count: got %0d exp 2", vq_cyc.size() - n0); end
    checks++; if ({data_out, parity_err, frame_err} !== {8'h01, 2'b00}) begin
      errors++; $display("FAIL brk_next: got %h/%b%b exp 01/00", data_out, parity_err, frame_err); end
  endtask

  task automatic test_false_start;
    int n0;
    n0 = vq_cyc.size();
    drive(1'b0, 4);
    drive(1'b1, 2);
    checks++; if (active_flag !== 1'b1) begin errors++; $display("FAIL fs_active_hi: got %b exp 1", active_flag); end
    drive(1'b1, 64);
    checks++; if (vq_cyc.size() !== n0) begin errors++; $display("FAIL fs_count: got %0d exp 0", vq_cyc.size() - n0); end
    checks++; if ({active_flag, done_flag} !== 2'b00) begin errors++; $display("FAIL fs_flags: got %b exp 00", {active_flag, done_flag}); end
  endtask

  task automatic test_back_to_back;
    int n0, c0, c1;
    n0 = vq_cyc.size();
    send_frame(8'h00, 1'b0, 1'b1, 11, -1, c0);
    send_frame(8'hFF, 1'b0, 1'b1, 11, -1, c1);
    drive(1'b1, 16);
    checks++; if (vq_cyc.size() !== n0 + 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", vq_cyc.size() - n0); end
    checks++; if (vq_cyc[n0] - c0 !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d exp %0d", vq_cyc[n0] - c0, LAT); end
    checks++; if (vq_cyc[n0+1] - vq_cyc[n0] !== 11 * OS) begin errors++; $display("FAIL b2b_gap: got %0d exp %0d", vq_cyc[n0+1] - vq_cyc[n0], 11 * OS); end
    checks++; if ({vq_data[n0], vq_data[n0+1]} !== 16'h00FF) begin errors++; $display("FAIL b2b_data: got %h %h exp 00 ff", vq_data[n0], vq_data[n0+1]); end
  endtask

  task automatic test_reset_mid;
    int n0, c0;
    n0 = vq_cyc.size();
    send_frame(8'h55, 1'b0, 1'b1, 5, -1, c0);
    @(posedge baud_clk); #1;
    reset_n = 1'b0;
    data_rx = 1'b1;
    #2;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h exp 00", data_out); end
    checks++; if ({parity_rx, data_valid, parity_err, frame_err, active_flag, done_flag} !== 6'b0) begin
      errors++; $display("FAIL rmid_flags: got %b exp 000000",
        {parity_rx, data_valid, parity_err, frame_err, active_flag, done_flag}); end
    repeat (2) @(posedge baud_clk);
    #1 reset_n = 1'b1;
    drive(1'b1, 32);
    send_frame(8'h12, 1'b0, 1'b1, 11, -1, c0);
    drive(1'b1, 16);
    checks++; if (vq_cyc.size() !== n0 + 1) begin errors++; $display("FAIL rmid_count: got %0d exp 1", vq_cyc.size() - n0); end
    checks++; if ({data_out, parity_err, frame_err} !== {8'h12, 2'b00}) begin
      errors++; $display("FAIL rmid_next: got %h/%b%b exp 12/00", data_out, parity_err, frame_err); end
    checks++; if (vq_cyc[n0] - c0 !== LAT) begin errors++; $display("FAIL rmid_latency: got %0d exp %0d", vq_cyc[n0] - c0, LAT); end
  endtask

  task automatic test_glitch;
    int c0;
    logic [7:0] exp_d;
    logic exp_pe;
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_d = 8'hA5; exp_pe = 1'b0;
`else
    exp_d = 8'hAD; exp_pe = 1'b1;
`endif
    // The single-cycle glitch lands exactly on the sample point of data bit 3.
    send_frame(8'hA5, 1'b0, 1'b1, 11, 4 * OS + OS / 2, c0);
    drive(1'b1, 16);
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL glitch_data: got %h exp %h", data_out, exp_d); end
    checks++; if (parity_err !== exp_pe) begin errors++; $display("FAIL glitch_perr: got %b exp %b", parity_err, exp_pe); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_break;
    test_false_start;
    test_back_to_back;
    test_reset_mid;
    test_glitch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
